// File: rtl/accelerator_dnc_pkg.sv
// Shared types and Q-format helpers for the DNC accelerator write path.
// Optional build macro: ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN selects the saturating multiply.
package accelerator_dnc_pkg;

    localparam int MAX_DATA_SIZE = 64;
    localparam int WIDE_SIZE     = 2 * MAX_DATA_SIZE + 2;

    typedef logic [WIDE_SIZE-1:0] wide_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        WAIT    = 3'd2,
        MUL1    = 3'd3,
        MUL2    = 3'd4,
        OUTPUT  = 3'd5,
        END     = 3'd6
    } write_weighting_state_t;

    function automatic wide_t fixed_one(input int frac_size);
        return wide_t'(1'b1) << frac_size;
    endfunction

    // Operands are at most MAX_DATA_SIZE+1 bits wide, so the product never overflows wide_t.
    function automatic wide_t fixed_mul(input wide_t a, input wide_t b, input int frac_size,
                                        input int data_size);
        wide_t product_s;
        wide_t limit_s;
        product_s = (a * b) >> frac_size;
        limit_s   = (wide_t'(1'b1) << data_size) - wide_t'(1'b1);
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN
        if (product_s > limit_s) begin
            return limit_s;
        end else begin
            return product_s;
        end
`else
        return product_s & limit_s;
`endif
    endfunction

endpackage

// File: rtl/accelerator_write_weighting_multiplier.sv
// Combinational unsigned Q-format multiply: (a*b)>>FRAC_SIZE reduced to DATA_SIZE bits.
// Honours ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN through the package helper.
module accelerator_write_weighting_multiplier
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE = 64,
    parameter int FRAC_SIZE = 32,
    parameter int A_SIZE    = 64,
    parameter int B_SIZE    = 64
) (
    input  logic [A_SIZE-1:0]    a,
    input  logic [B_SIZE-1:0]    b,
    output logic [DATA_SIZE-1:0] product
);

    assign product = DATA_SIZE'(fixed_mul(wide_t'(a), wide_t'(b), FRAC_SIZE, DATA_SIZE));

endmodule

// File: rtl/accelerator_write_weighting.sv
// DNC write weighting w(j) = gw*(ga*a(j) + (1-ga)*c(j)), streamed one element at a time.
// Optional build macro: ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN (gate clamping and saturation).
module accelerator_write_weighting
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64,
    parameter int FRAC_SIZE    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [DATA_SIZE-1:0] ALLOCATION_GATE,
    input  logic [DATA_SIZE-1:0] WRITE_GATE,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic                 A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] A_IN,
    output logic                 A_OUT_ENABLE,
    input  logic                 C_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] C_IN,
    output logic                 C_OUT_ENABLE,
    output logic                 W_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] W_OUT
);

    localparam logic [DATA_SIZE-1:0]    ONE       = DATA_SIZE'(fixed_one(FRAC_SIZE));
    localparam logic [DATA_SIZE-1:0]    ZERO      = {DATA_SIZE{1'b0}};
    localparam logic [DATA_SIZE-1:0]    ALL_ONES  = {DATA_SIZE{1'b1}};
    localparam logic [DATA_SIZE-1:0]    UNIT      = {{(DATA_SIZE-1){1'b0}}, 1'b1};
    localparam logic [CONTROL_SIZE-1:0] IDX_ZERO  = {CONTROL_SIZE{1'b0}};
    localparam logic [CONTROL_SIZE-1:0] IDX_UNIT  = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

    write_weighting_state_t state_r;
    write_weighting_state_t state_next_s;

    logic [CONTROL_SIZE-1:0] index_r;
    logic [DATA_SIZE-1:0]    n_r;
    logic [DATA_SIZE-1:0]    ga_r;
    logic [DATA_SIZE-1:0]    gw_r;
    logic [DATA_SIZE-1:0]    a_r;
    logic [DATA_SIZE-1:0]    c_r;
    logic                    a_flag_r;
    logic                    c_flag_r;
    logic [DATA_SIZE-1:0]    p_a_r;
    logic [DATA_SIZE-1:0]    p_c_r;

    logic                    ready_r;
    logic                    a_out_enable_r;
    logic                    c_out_enable_r;
    logic                    w_out_enable_r;
    logic [DATA_SIZE-1:0]    w_out_r;

    logic                    capturing_s;
    logic                    both_captured_s;
    logic                    last_element_s;
    logic [DATA_SIZE-1:0]    n_minus_one_s;
    logic [DATA_SIZE-1:0]    ga_sample_s;
    logic [DATA_SIZE-1:0]    gw_sample_s;
    logic [DATA_SIZE-1:0]    one_minus_ga_s;
    logic [DATA_SIZE-1:0]    p_a_s;
    logic [DATA_SIZE-1:0]    p_c_s;
    logic [DATA_SIZE:0]      sum_s;
    logic [DATA_SIZE:0]      sum_eff_s;
    logic [DATA_SIZE-1:0]    w_s;

    assign capturing_s     = (state_r == REQUEST) || (state_r == WAIT);
    // An enable arriving this cycle counts, so REQUEST can leave directly for MUL1.
    assign both_captured_s = (a_flag_r || A_IN_ENABLE) && (c_flag_r || C_IN_ENABLE);
    assign n_minus_one_s   = n_r - UNIT;
    assign last_element_s  = (index_r == CONTROL_SIZE'(n_minus_one_s));
    // Without saturation a gate above ONE makes ONE-ga wrap; that is intended behaviour.
    assign one_minus_ga_s  = ONE - ga_r;
    assign sum_s           = {1'b0, p_a_r} + {1'b0, p_c_r};

`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN
    assign ga_sample_s = (ALLOCATION_GATE > ONE) ? ONE : ALLOCATION_GATE;
    assign gw_sample_s = (WRITE_GATE > ONE) ? ONE : WRITE_GATE;
    assign sum_eff_s   = sum_s[DATA_SIZE] ? {1'b0, ALL_ONES} : sum_s;
`else
    assign ga_sample_s = ALLOCATION_GATE;
    assign gw_sample_s = WRITE_GATE;
    assign sum_eff_s   = sum_s;
`endif

    accelerator_write_weighting_multiplier #(
        .DATA_SIZE(DATA_SIZE), .FRAC_SIZE(FRAC_SIZE), .A_SIZE(DATA_SIZE), .B_SIZE(DATA_SIZE)
    ) u_mul_a (
        .a(ga_r), .b(a_r), .product(p_a_s)
    );

    accelerator_write_weighting_multiplier #(
        .DATA_SIZE(DATA_SIZE), .FRAC_SIZE(FRAC_SIZE), .A_SIZE(DATA_SIZE), .B_SIZE(DATA_SIZE)
    ) u_mul_c (
        .a(one_minus_ga_s), .b(c_r), .product(p_c_s)
    );

    accelerator_write_weighting_multiplier #(
        .DATA_SIZE(DATA_SIZE), .FRAC_SIZE(FRAC_SIZE), .A_SIZE(DATA_SIZE), .B_SIZE(DATA_SIZE + 1)
    ) u_mul_w (
        .a(gw_r), .b(sum_eff_s), .product(w_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_next_s = (SIZE_N_IN == ZERO) ? END : REQUEST;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQUEST, WAIT: begin
                if (both_captured_s) begin
                    state_next_s = MUL1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            MUL1:    state_next_s = MUL2;
            MUL2:    state_next_s = OUTPUT;
            OUTPUT: begin
                if (last_element_s) begin
                    state_next_s = END;
                end else begin
                    state_next_s = REQUEST;
                end
            end
            END:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Operand capture, index counter and MUL1 partial products.
    always_ff @(posedge CLK) begin
        if (RST) begin
            index_r  <= IDX_ZERO;
            n_r      <= ZERO;
            ga_r     <= ZERO;
            gw_r     <= ZERO;
            a_r      <= ZERO;
            c_r      <= ZERO;
            a_flag_r <= 1'b0;
            c_flag_r <= 1'b0;
            p_a_r    <= ZERO;
            p_c_r    <= ZERO;
        end else begin
            if ((state_r == IDLE) && START) begin
                n_r     <= SIZE_N_IN;
                ga_r    <= ga_sample_s;
                gw_r    <= gw_sample_s;
                index_r <= IDX_ZERO;
            end
            if (capturing_s && A_IN_ENABLE) begin
                a_r      <= A_IN;
                a_flag_r <= 1'b1;
            end
            if (capturing_s && C_IN_ENABLE) begin
                c_r      <= C_IN;
                c_flag_r <= 1'b1;
            end
            if (state_r == MUL1) begin
                p_a_r <= p_a_s;
                p_c_r <= p_c_s;
            end
            if (state_r == OUTPUT) begin
                a_flag_r <= 1'b0;
                c_flag_r <= 1'b0;
                if (!last_element_s) begin
                    index_r <= index_r + IDX_UNIT;
                end
            end
        end
    end

    // Registered outputs; READY trails END by one cycle and W_OUT holds between pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ready_r        <= 1'b0;
            a_out_enable_r <= 1'b0;
            c_out_enable_r <= 1'b0;
            w_out_enable_r <= 1'b0;
            w_out_r        <= ZERO;
        end else begin
            ready_r        <= (state_r == END);
            a_out_enable_r <= (state_next_s == REQUEST);
            c_out_enable_r <= (state_next_s == REQUEST);
            w_out_enable_r <= (state_r == MUL2);
            if (state_r == MUL2) begin
                w_out_r <= w_s;
            end
        end
    end

    assign READY        = ready_r;
    assign A_OUT_ENABLE = a_out_enable_r;
    assign C_OUT_ENABLE = c_out_enable_r;
    assign W_OUT_ENABLE = w_out_enable_r;
    assign W_OUT        = w_out_r;

endmodule

// File: tb/tb_accelerator_write_weighting.sv
// Self-checking bench for accelerator_write_weighting: directed and randomized vectors
// compared against an arithmetic reference of the write-weighting formula.
module tb_accelerator_write_weighting;

    localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

    logic        CLK = 1'b0;
    logic        RST, START, READY;
    logic [63:0] ALLOCATION_GATE, WRITE_GATE, SIZE_N_IN;
    logic        A_IN_ENABLE, A_OUT_ENABLE, C_IN_ENABLE, C_OUT_ENABLE, W_OUT_ENABLE;
    logic [63:0] A_IN, C_IN, W_OUT;

    always #5 CLK = ~CLK;

    accelerator_write_weighting dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY),
        .ALLOCATION_GATE(ALLOCATION_GATE), .WRITE_GATE(WRITE_GATE), .SIZE_N_IN(SIZE_N_IN),
        .A_IN_ENABLE(A_IN_ENABLE), .A_IN(A_IN), .A_OUT_ENABLE(A_OUT_ENABLE),
        .C_IN_ENABLE(C_IN_ENABLE), .C_IN(C_IN), .C_OUT_ENABLE(C_OUT_ENABLE),
        .W_OUT_ENABLE(W_OUT_ENABLE), .W_OUT(W_OUT)
    );

    int          tests = 0;
    int          fails = 0;
    longint      cyc = 0;
    logic [63:0] w_q[$];
    longint      w_cyc_q[$];
    int          ready_cnt, req_cnt, creq_cnt;
    longint      ready_cyc, first_req_cyc;
    logic [63:0] av[8];
    logic [63:0] cv[8];

    always @(posedge CLK) cyc <= cyc + 1;

    // Output monitor: records every pulse with the cycle it was seen in.
    always @(negedge CLK) begin
        if (W_OUT_ENABLE === 1'b1) begin
            w_q.push_back(W_OUT);
            w_cyc_q.push_back(cyc);
        end
        if (READY === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (A_OUT_ENABLE === 1'b1) begin
            if (req_cnt == 0) first_req_cyc = cyc;
            req_cnt++;
        end
        if (C_OUT_ENABLE === 1'b1) creq_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // w = gw*(ga*a + (1-ga)*c) in Q32.32 with the truncation/saturation rules of the block.
    function automatic logic [63:0] ref_w(input logic [63:0] ga_in, input logic [63:0] gw_in,
                                          input logic [63:0] a, input logic [63:0] c);
        logic [63:0]  ga, gw, pa, pc;
        logic [127:0] t;
        logic [64:0]  s;
        logic [191:0] prod;
        ga = ga_in;
        gw = gw_in;
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN
        if (ga > ONE) ga = ONE;
        if (gw > ONE) gw = ONE;
`endif
        t  = ({64'd0, ga} * {64'd0, a}) >> 32;
        pa = t[63:0];
        t  = ({64'd0, ONE - ga} * {64'd0, c}) >> 32;
        pc = t[63:0];
        s  = {1'b0, pa} + {1'b0, pc};
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN
        if (s[64]) s = {1'b0, {64{1'b1}}};
`endif
        prod = ({128'd0, gw} * {127'd0, s}) >> 32;
`ifdef ACCELERATOR_WRITE_WEIGHTING_SATURATION_EN
        if (prod[191:64] != 128'd0) return {64{1'b1}};
`endif
        return prod[63:0];
    endfunction

    task automatic wait_req(input string tag, output bit ok);
        int waited = 0;
        while (A_OUT_ENABLE !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check({tag, "_a_req"}, 64'(A_OUT_ENABLE), 64'd1);
        check({tag, "_c_req"}, 64'(C_OUT_ENABLE), 64'd1);
        ok = (A_OUT_ENABLE === 1'b1);
    endtask

    // mode 0: a and c during REQUEST; mode 1: c early (overwritten once), a 3 cycles later;
    // mode 2: independent random delays.
    task automatic deliver(input int j, input int mode);
        int da, dc;
        case (mode)
            0: begin
                A_IN = av[j]; C_IN = cv[j]; A_IN_ENABLE = 1'b1; C_IN_ENABLE = 1'b1;
                tick();
                A_IN_ENABLE = 1'b0; C_IN_ENABLE = 1'b0;
                A_IN = {$urandom, $urandom}; C_IN = {$urandom, $urandom};
            end
            1: begin
                C_IN = {$urandom, $urandom}; C_IN_ENABLE = 1'b1;
                tick();
                C_IN = cv[j];
                tick();
                C_IN_ENABLE = 1'b0;
                tick();
                A_IN = av[j]; A_IN_ENABLE = 1'b1;
                tick();
                A_IN_ENABLE = 1'b0;
            end
            default: begin
                da = $urandom_range(0, 3);
                dc = $urandom_range(0, 3);
                A_IN = av[j]; C_IN = cv[j];
                for (int d = 0; d < 4; d++) begin
                    A_IN_ENABLE = (d == da);
                    C_IN_ENABLE = (d == dc);
                    tick();
                end
                A_IN_ENABLE = 1'b0; C_IN_ENABLE = 1'b0;
            end
        endcase
    endtask

    task automatic run_vector(input string name, input int n, input logic [63:0] ga,
                              input logic [63:0] gw, input int mode, input bit busy_start);
        bit     ok;
        int     waited;
        longint s_edge;
        w_q.delete(); w_cyc_q.delete();
        ready_cnt = 0; req_cnt = 0; creq_cnt = 0;
        ALLOCATION_GATE = ga; WRITE_GATE = gw; SIZE_N_IN = 64'(n); START = 1'b1;
        s_edge = cyc + 1;
        tick();
        START = 1'b0;
        ALLOCATION_GATE = {$urandom, $urandom}; WRITE_GATE = {$urandom, $urandom};
        for (int j = 0; j < n; j++) begin
            wait_req($sformatf("%s_%0d", name, j), ok);
            if (!ok) return;
            deliver(j, mode);
            if (busy_start && j == 0) begin
                SIZE_N_IN = 64'd9; START = 1'b1;
                tick();
                START = 1'b0;
            end
        end
        waited = 0;
        while (ready_cnt == 0 && waited < 40) begin
            tick();
            waited++;
        end
        tick(); tick();
        check({name, "_ready_count"}, 64'(ready_cnt), 64'd1);
        check({name, "_w_count"}, 64'(w_q.size()), 64'(n));
        check({name, "_req_count"}, 64'(req_cnt), 64'(n));
        check({name, "_creq_count"}, 64'(creq_cnt), 64'(n));
        if (n == 0) begin
            check({name, "_ready_latency"}, 64'(ready_cyc - s_edge), 64'd1);
        end else if (w_q.size() == n) begin
            check({name, "_first_req"}, 64'(first_req_cyc), 64'(s_edge));
            check({name, "_ready_after_w"}, 64'(ready_cyc - w_cyc_q[n-1]), 64'd2);
            check({name, "_w_hold"}, W_OUT, ref_w(ga, gw, av[n-1], cv[n-1]));
            for (int j = 0; j < n; j++) begin
                check($sformatf("%s_w%0d", name, j), w_q[j], ref_w(ga, gw, av[j], cv[j]));
                if (mode == 0 && j > 0)
                    check($sformatf("%s_gap%0d", name, j), 64'(w_cyc_q[j] - w_cyc_q[j-1]), 64'd4);
            end
        end
    endtask

    initial begin
        bit          ok;
        int          n;
        logic [63:0] ga, gw;
        RST = 1'b1; START = 1'b0; ALLOCATION_GATE = '0; WRITE_GATE = '0; SIZE_N_IN = '0;
        A_IN_ENABLE = 1'b0; C_IN_ENABLE = 1'b0; A_IN = '0; C_IN = '0;
        tick(); tick();
        check("reset_ready", 64'(READY), 64'd0);
        check("reset_a_req", 64'(A_OUT_ENABLE), 64'd0);
        check("reset_c_req", 64'(C_OUT_ENABLE), 64'd0);
        check("reset_w_en", 64'(W_OUT_ENABLE), 64'd0);
        check("reset_w", W_OUT, 64'd0);
        RST = 1'b0;
        tick();

        // ga=0 passes c through
        for (int j = 0; j < 3; j++) av[j] = {$urandom, $urandom};
        cv[0] = ONE; cv[1] = ONE >> 1; cv[2] = 64'd0;
        run_vector("ga_zero", 3, 64'd0, ONE, 0, 1'b0);
        check("ga_zero_w1_const", (w_q.size() > 1) ? w_q[1] : 64'hX, ONE >> 1);

        // ga=ONE passes a through
        av[0] = ONE >> 2; av[1] = ONE >> 1; av[2] = ONE >> 2;
        for (int j = 0; j < 3; j++) cv[j] = {$urandom, $urandom};
        run_vector("ga_one", 3, ONE, ONE, 0, 1'b0);
        check("ga_one_hold_const", W_OUT, ONE >> 2);

        // half gates, a=ONE, c=0 -> ONE/4
        for (int j = 0; j < 3; j++) begin av[j] = ONE; cv[j] = 64'd0; end
        run_vector("half", 3, ONE >> 1, ONE >> 1, 0, 1'b0);
        check("half_hold_const", W_OUT, ONE >> 2);

        // same data, late/overwritten operands then the fast path
        for (int j = 0; j < 3; j++) begin av[j] = {32'd0, $urandom}; cv[j] = {32'd0, $urandom}; end
        ga = {32'd0, $urandom};
        run_vector("late_order", 3, ga, ONE, 1, 1'b0);
        run_vector("fast_order", 3, ga, ONE, 0, 1'b0);

        run_vector("empty", 0, ONE, ONE, 0, 1'b0);
        run_vector("busy_start", 3, ONE >> 1, ONE, 0, 1'b1);

        // reset while j=1 is in MUL1
        for (int j = 0; j < 3; j++) begin av[j] = {32'd0, $urandom}; cv[j] = {32'd0, $urandom}; end
        ALLOCATION_GATE = ONE >> 1; WRITE_GATE = ONE; SIZE_N_IN = 64'd3; START = 1'b1;
        tick();
        START = 1'b0;
        for (int j = 0; j < 2; j++) begin
            wait_req($sformatf("abort_%0d", j), ok);
            deliver(j, 0);
        end
        check("abort_pre_w", W_OUT, ref_w(ONE >> 1, ONE, av[0], cv[0]));
        RST = 1'b1;
        tick();
        check("abort_w", W_OUT, 64'd0);
        check("abort_w_en", 64'(W_OUT_ENABLE), 64'd0);
        check("abort_a_req", 64'(A_OUT_ENABLE), 64'd0);
        check("abort_ready", 64'(READY), 64'd0);
        RST = 1'b0;
        ready_cnt = 0; req_cnt = 0; w_q.delete();
        repeat (12) tick();
        check("abort_no_ready", 64'(ready_cnt), 64'd0);
        check("abort_no_req", 64'(req_cnt), 64'd0);
        check("abort_no_w", 64'(w_q.size()), 64'd0);
        run_vector("after_abort", 3, ONE >> 1, ONE, 0, 1'b0);

        // gate above ONE: wraps by default, clamps with saturation enabled
        for (int j = 0; j < 3; j++) begin av[j] = {32'd0, $urandom}; cv[j] = {32'd0, $urandom}; end
        run_vector("ga_over", 3, ONE << 1, ONE >> 1, 0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            n  = $urandom_range(1, 5);
            ga = ($urandom_range(0, 3) == 0) ? ONE : {32'd0, $urandom};
            gw = ($urandom_range(0, 3) == 0) ? ONE : {32'd0, $urandom};
            for (int j = 0; j < n; j++) begin av[j] = {32'd0, $urandom}; cv[j] = {32'd0, $urandom}; end
            run_vector($sformatf("rand%0d", r), n, ga, gw, 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
